// File: rtl/mem_bus_arbiter.sv
// Memory-port arbiter: CPU fetch/read/write plus one external requester share a single
// memory port, one transaction at a time, with a watchdog that aborts hung transactions.
module mem_bus_arbiter #(
  parameter int TIMEOUT = 256,
  parameter int CNTW    = 9
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_read_req,
  input  logic        i_read_w,
  input  logic        i_read_hw,
  input  logic [31:0] i_read_adr,
  input  logic        d_read_req,
  input  logic        d_read_w,
  input  logic        d_read_hw,
  input  logic [31:0] d_read_adr,
  input  logic        d_write_req,
  input  logic        d_write_w,
  input  logic        d_write_hw,
  input  logic [31:0] d_write_adr,
  input  logic [31:0] d_write_data,
  output logic        read_valid,
  output logic [31:0] read_data,
  output logic        write_finish,
  input  logic        x_req,
  input  logic        x_we,
  input  logic [31:0] x_adr,
  input  logic [31:0] x_wdata,
  output logic        x_done,
  output logic [31:0] x_rdata,
  output logic        m_req,
  output logic        m_we,
  output logic        m_w,
  output logic        m_hw,
  output logic [31:0] m_adr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        timeout_err,
  output logic [31:0] err_adr,
  output logic [1:0]  dbg_state
);

  // Handshake: requesters hold a level request (with stable fields) until their one-cycle
  // completion pulse; m_req is held with stable fields until the one-cycle m_ack pulse.
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_BUSY = 2'd1, S_RESP = 2'd2, S_GAP = 2'd3} state_t;

  localparam logic [1:0] OWN_IR = 2'd0;
  localparam logic [1:0] OWN_DR = 2'd1;
  localparam logic [1:0] OWN_DW = 2'd2;
  localparam logic [1:0] OWN_X  = 2'd3;
  localparam logic [CNTW-1:0] CNT_LAST = CNTW'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [1:0]  owner_q, owner_d;
  logic [CNTW-1:0] cnt_q, cnt_d;
  logic        last_ext_q, last_ext_d;
  logic        m_req_q, m_req_d;
  logic        m_we_q, m_we_d;
  logic        m_w_q, m_w_d;
  logic        m_hw_q, m_hw_d;
  logic [31:0] m_adr_q, m_adr_d;
  logic [31:0] m_wdata_q, m_wdata_d;
  logic        read_valid_q, read_valid_d;
  logic [31:0] read_data_q, read_data_d;
  logic        write_finish_q, write_finish_d;
  logic        x_done_q, x_done_d;
  logic [31:0] x_rdata_q, x_rdata_d;
  logic        timeout_err_q, timeout_err_d;
  logic [31:0] err_adr_q, err_adr_d;

  logic        cpu_any;
  logic        grant_x;
  logic        done;
  logic [31:0] resp_data;

  always_comb begin
    cpu_any   = d_write_req | d_read_req | i_read_req;
    // On a tie the group not served last wins; a lone requester always wins.
    grant_x   = x_req & (~cpu_any | ~last_ext_q);
    done      = (state_q == S_BUSY) & (m_ack | (cnt_q == CNT_LAST));
    resp_data = m_ack ? m_rdata : 32'hFFFF_FFFF;

    state_d        = state_q;
    owner_d        = owner_q;
    cnt_d          = cnt_q;
    last_ext_d     = last_ext_q;
    m_req_d        = m_req_q;
    m_we_d         = m_we_q;
    m_w_d          = m_w_q;
    m_hw_d         = m_hw_q;
    m_adr_d        = m_adr_q;
    m_wdata_d      = m_wdata_q;
    read_valid_d   = 1'b0;
    read_data_d    = read_data_q;
    write_finish_d = 1'b0;
    x_done_d       = 1'b0;
    x_rdata_d      = x_rdata_q;
    timeout_err_d  = timeout_err_q;
    err_adr_d      = err_adr_q;

    case (state_q)
      S_IDLE: begin
        if (cpu_any | x_req) begin
          state_d = S_BUSY;
          m_req_d = 1'b1;
          cnt_d   = '0;
          if (grant_x) begin
            owner_d   = OWN_X;
            m_adr_d   = x_adr;
            m_we_d    = x_we;
            m_w_d     = 1'b1;
            m_hw_d    = 1'b0;
            m_wdata_d = x_we ? x_wdata : 32'h0;
          end else if (d_write_req) begin
            owner_d   = OWN_DW;
            m_adr_d   = d_write_adr;
            m_we_d    = 1'b1;
            m_w_d     = d_write_w;
            m_hw_d    = d_write_hw;
            m_wdata_d = d_write_data;
          end else if (d_read_req) begin
            owner_d   = OWN_DR;
            m_adr_d   = d_read_adr;
            m_we_d    = 1'b0;
            m_w_d     = d_read_w;
            m_hw_d    = d_read_hw;
            m_wdata_d = 32'h0;
          end else begin
            owner_d   = OWN_IR;
            m_adr_d   = i_read_adr;
            m_we_d    = 1'b0;
            m_w_d     = i_read_w;
            m_hw_d    = i_read_hw;
            m_wdata_d = 32'h0;
          end
        end
      end
      S_BUSY: begin
        if (done) begin
          m_req_d = 1'b0;
          state_d = S_RESP;
          case (owner_q)
            OWN_IR, OWN_DR: begin
              read_valid_d = 1'b1;
              read_data_d  = resp_data;
            end
            OWN_DW: write_finish_d = 1'b1;
            default: begin
              x_done_d  = 1'b1;
              x_rdata_d = resp_data;
            end
          endcase
          // An ack arriving on the expiry cycle still counts as a normal completion.
          if (!m_ack) begin
            timeout_err_d = 1'b1;
            if (!timeout_err_q) err_adr_d = m_adr_q;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_RESP: begin
        last_ext_d = (owner_q == OWN_X);
        state_d    = S_GAP;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q        <= S_IDLE;
      owner_q        <= OWN_IR;
      cnt_q          <= '0;
      last_ext_q     <= 1'b1;
      m_req_q        <= 1'b0;
      m_we_q         <= 1'b0;
      m_w_q          <= 1'b0;
      m_hw_q         <= 1'b0;
      m_adr_q        <= 32'h0;
      m_wdata_q      <= 32'h0;
      read_valid_q   <= 1'b0;
      read_data_q    <= 32'h0;
      write_finish_q <= 1'b0;
      x_done_q       <= 1'b0;
      x_rdata_q      <= 32'h0;
      timeout_err_q  <= 1'b0;
      err_adr_q      <= 32'h0;
    end else begin
      state_q        <= state_d;
      owner_q        <= owner_d;
      cnt_q          <= cnt_d;
      last_ext_q     <= last_ext_d;
      m_req_q        <= m_req_d;
      m_we_q         <= m_we_d;
      m_w_q          <= m_w_d;
      m_hw_q         <= m_hw_d;
      m_adr_q        <= m_adr_d;
      m_wdata_q      <= m_wdata_d;
      read_valid_q   <= read_valid_d;
      read_data_q    <= read_data_d;
      write_finish_q <= write_finish_d;
      x_done_q       <= x_done_d;
      x_rdata_q      <= x_rdata_d;
      timeout_err_q  <= timeout_err_d;
      err_adr_q      <= err_adr_d;
    end
  end

  assign read_valid   = read_valid_q;
  assign read_data    = read_data_q;
  assign write_finish = write_finish_q;
  assign x_done       = x_done_q;
  assign x_rdata      = x_rdata_q;
  assign m_req        = m_req_q;
  assign m_we         = m_we_q;
  assign m_w          = m_w_q;
  assign m_hw         = m_hw_q;
  assign m_adr        = m_adr_q;
  assign m_wdata      = m_wdata_q;
  assign timeout_err  = timeout_err_q;
  assign err_adr      = err_adr_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: transaction-timeline model (grant cycle, ack cycle, pulse
// cycle) checked against the DUT every cycle, plus directed literal checks.
module tb_mem_bus_arbiter;
  localparam int TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        i_read_req, i_read_w, i_read_hw;
  logic [31:0] i_read_adr;
  logic        d_read_req, d_read_w, d_read_hw;
  logic [31:0] d_read_adr;
  logic        d_write_req, d_write_w, d_write_hw;
  logic [31:0] d_write_adr, d_write_data;
  logic        read_valid, write_finish, x_done;
  logic [31:0] read_data, x_rdata;
  logic        x_req, x_we;
  logic [31:0] x_adr, x_wdata;
  logic        m_req, m_we, m_w, m_hw, m_ack;
  logic [31:0] m_adr, m_wdata, m_rdata;
  logic        timeout_err;
  logic [31:0] err_adr;
  logic [1:0]  dbg_state;

  mem_bus_arbiter #(.TIMEOUT(TO), .CNTW(9)) dut (
    .clk(clk), .rst(rst),
    .i_read_req(i_read_req), .i_read_w(i_read_w), .i_read_hw(i_read_hw), .i_read_adr(i_read_adr),
    .d_read_req(d_read_req), .d_read_w(d_read_w), .d_read_hw(d_read_hw), .d_read_adr(d_read_adr),
    .d_write_req(d_write_req), .d_write_w(d_write_w), .d_write_hw(d_write_hw),
    .d_write_adr(d_write_adr), .d_write_data(d_write_data),
    .read_valid(read_valid), .read_data(read_data), .write_finish(write_finish),
    .x_req(x_req), .x_we(x_we), .x_adr(x_adr), .x_wdata(x_wdata),
    .x_done(x_done), .x_rdata(x_rdata),
    .m_req(m_req), .m_we(m_we), .m_w(m_w), .m_hw(m_hw), .m_adr(m_adr), .m_wdata(m_wdata),
    .m_rdata(m_rdata), .m_ack(m_ack),
    .timeout_err(timeout_err), .err_adr(err_adr), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_fail = 0;
  int cyc = 0;

  // requester index: 0 = i_read, 1 = d_read, 2 = d_write, 3 = external
  bit          rq[4];
  logic [31:0] ra[4], rd[4];
  bit          rw[4], rh[4];
  bit          xwe;
  bit          rst_lvl;

  // current transaction timeline
  bit          active;
  int          own, bstart, pcyc, next_free, ack_cyc, last_dec;
  logic [31:0] t_adr, t_wdata, ack_data;
  bit          t_we, t_w, t_hw;

  // model of sticky / holding outputs
  logic [31:0] exp_rd, exp_xrd, exp_eadr;
  bit          exp_terr, last_ext;

  int          force_d = -1;
  bit          hold_all, use_fdata;
  logic [31:0] fdata;
  int          raise_pct;
  int          grant_log[$];
  int          rv_cnt, wf_cnt, xd_cnt, rv_cyc, wf_cyc;

  // ---------------- scoreboard helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic model_reset();
    active    = 0;
    next_free = 0;
    exp_rd    = 32'h0;
    exp_xrd   = 32'h0;
    exp_eadr  = 32'h0;
    exp_terr  = 0;
    last_ext  = 1;
  endtask

  // CPU group: write > read > fetch; CPU vs external: whoever was not served last.
  function automatic int pick();
    bit cpu_wants;
    cpu_wants = rq[0] | rq[1] | rq[2];
    if (rq[3] && !(cpu_wants && last_ext)) return 3;
    if (rq[2]) return 2;
    if (rq[1]) return 1;
    return 0;
  endfunction

  // ---------------- driver: one clock cycle ----------------
  task automatic step();
    int d;
    bit exp_mreq, pulse;
    @(posedge clk);
    #1;
    cyc++;
    if (active && !hold_all && cyc == pcyc + 1) rq[own] = 0;
    if (raise_pct > 0) begin
      for (int k = 0; k < 4; k++) begin
        if (!rq[k] && $urandom_range(0, 99) < raise_pct) begin
          rq[k] = 1;
          ra[k] = $urandom;
          rd[k] = $urandom;
          rw[k] = 1'($urandom_range(0, 1));
          rh[k] = 1'($urandom_range(0, 1));
          if (k == 3) xwe = 1'($urandom_range(0, 1));
        end
      end
    end
    if (!rst_lvl && cyc >= next_free && (rq[0] | rq[1] | rq[2] | rq[3])) begin
      own     = pick();
      t_adr   = ra[own];
      t_we    = (own == 2) || (own == 3 && xwe);
      t_w     = (own == 3) ? 1'b1 : rw[own];
      t_hw    = (own == 3) ? 1'b0 : rh[own];
      t_wdata = (own == 2) ? rd[2] : ((own == 3 && xwe) ? rd[3] : 32'h0);
      d       = (force_d >= 0) ? force_d
              : (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, TO)));
      bstart    = cyc + 1;
      pcyc      = bstart + ((d > 0) ? d : TO);
      next_free = pcyc + 2;
      ack_cyc   = (d > 0) ? bstart + d - 1 : -1;
      ack_data  = use_fdata ? fdata : $urandom;
      active    = 1;
      last_dec  = cyc;
      grant_log.push_back(own);
    end
    if (active && cyc == pcyc) begin
      logic [31:0] data;
      data = (ack_cyc >= 0) ? ack_data : 32'hFFFF_FFFF;
      if (own < 2) exp_rd = data;
      if (own == 3) exp_xrd = data;
      if (ack_cyc < 0) begin
        if (!exp_terr) exp_eadr = t_adr;
        exp_terr = 1;
      end
      last_ext = (own == 3);
    end
    rst          = rst_lvl;
    i_read_req   = rq[0]; i_read_adr  = ra[0]; i_read_w  = rw[0]; i_read_hw  = rh[0];
    d_read_req   = rq[1]; d_read_adr  = ra[1]; d_read_w  = rw[1]; d_read_hw  = rh[1];
    d_write_req  = rq[2]; d_write_adr = ra[2]; d_write_w = rw[2]; d_write_hw = rh[2];
    d_write_data = rd[2];
    x_req        = rq[3]; x_adr = ra[3]; x_wdata = rd[3]; x_we = xwe;
    m_ack        = active && (cyc == ack_cyc);
    m_rdata      = m_ack ? ack_data : $urandom;

    // ---------------- compare ----------------
    @(negedge clk);
    exp_mreq = active && cyc >= bstart && cyc < pcyc;
    pulse    = active && cyc == pcyc;
    chk("m_req", m_req, exp_mreq);
    if (exp_mreq) begin
      chk("m_adr", m_adr, t_adr);
      chk("m_we", m_we, t_we);
      chk("m_w", m_w, t_w);
      chk("m_hw", m_hw, t_hw);
      chk("m_wdata", m_wdata, t_wdata);
    end
    chk("read_valid", read_valid, pulse && own < 2);
    chk("write_finish", write_finish, pulse && own == 2);
    chk("x_done", x_done, pulse && own == 3);
    chk("read_data", read_data, exp_rd);
    chk("timeout_err", timeout_err, exp_terr);
    chk("err_adr", err_adr, exp_eadr);
    if (pulse && own == 3 && !t_we) chk("x_rdata", x_rdata, exp_xrd);
    if (read_valid)   begin rv_cnt++; rv_cyc = cyc; end
    if (write_finish) begin wf_cnt++; wf_cyc = cyc; end
    if (x_done)       xd_cnt++;
    if (rst_lvl) model_reset();
  endtask

  task automatic run_until_idle(input int max_cyc);
    int n;
    n = 0;
    while (((rq[0] | rq[1] | rq[2] | rq[3]) || (active && cyc < next_free)) && n < max_cyc) begin
      step();
      n++;
    end
    if (n >= max_cyc) begin
      n_cmp++;
      n_fail++;
      $display("FAIL idle_bound: still busy after %0d cycles, required idle", max_cyc);
    end
  endtask

  task automatic pulse_reset();
    rst_lvl = 1;
    step();
    rst_lvl = 0;
  endtask

  // ---------------- test sequence ----------------
  initial begin
    rst = 1'b1;
    i_read_req = 0; i_read_w = 0; i_read_hw = 0; i_read_adr = 0;
    d_read_req = 0; d_read_w = 0; d_read_hw = 0; d_read_adr = 0;
    d_write_req = 0; d_write_w = 0; d_write_hw = 0; d_write_adr = 0; d_write_data = 0;
    x_req = 0; x_we = 0; x_adr = 0; x_wdata = 0; m_ack = 0; m_rdata = 0;
    for (int k = 0; k < 4; k++) begin
      rq[k] = 0; ra[k] = 0; rd[k] = 0; rw[k] = 0; rh[k] = 0;
    end
    xwe = 0; rst_lvl = 1; hold_all = 0; use_fdata = 0; fdata = 0; raise_pct = 0;
    rv_cnt = 0; wf_cnt = 0; xd_cnt = 0; rv_cyc = 0; wf_cyc = 0;
    model_reset();
    step();
    step();
    chk("rst_m_req", m_req, 0);
    chk("rst_read_data", read_data, 32'h0);
    chk("rst_x_rdata", x_rdata, 32'h0);
    chk("rst_err_adr", err_adr, 32'h0);
    chk("rst_state", dbg_state, 2'd0);
    rst_lvl = 0;

    // single data read, ack on 3rd BUSY cycle
    force_d = 3; use_fdata = 1; fdata = 32'hDEADBEEF;
    rq[1] = 1; ra[1] = 32'h1000; rw[1] = 1; rh[1] = 0;
    step();
    step();
    chk("t1_m_req", m_req, 1);
    chk("t1_m_adr", m_adr, 32'h1000);
    chk("t1_m_we", m_we, 0);
    step(); step(); step();
    chk("t1_read_valid", read_valid, 1);
    chk("t1_read_data", read_data, 32'hDEADBEEF);
    chk("t1_write_finish", write_finish, 0);
    chk("t1_x_done", x_done, 0);
    step();
    chk("t1_pulse_width", read_valid, 0);
    run_until_idle(50);

    // CPU-group fixed priority
    grant_log.delete(); rv_cnt = 0; wf_cnt = 0;
    force_d = 1; fdata = 32'h0BAD_F00D;
    rq[0] = 1; ra[0] = 32'h100; rw[0] = 1;
    rq[1] = 1; ra[1] = 32'h200; rw[1] = 0; rh[1] = 1;
    rq[2] = 1; ra[2] = 32'h300; rw[2] = 1; rd[2] = 32'hCAFE_0001;
    run_until_idle(100);
    chk("prio_count", grant_log.size(), 3);
    if (grant_log.size() == 3) begin
      chk("prio_first_write", grant_log[0], 2);
      chk("prio_second_dread", grant_log[1], 1);
      chk("prio_third_iread", grant_log[2], 0);
    end
    chk("prio_wf_count", wf_cnt, 1);
    chk("prio_rv_count", rv_cnt, 2);

    // CPU vs external round robin, CPU first after reset
    pulse_reset();
    grant_log.delete(); xd_cnt = 0;
    use_fdata = 0; hold_all = 1;
    rq[1] = 1; ra[1] = 32'h40; rw[1] = 1;
    rq[3] = 1; ra[3] = 32'h80; xwe = 0;
    for (int i = 0; i < 40 && grant_log.size() < 4; i++) step();
    hold_all = 0; rq[1] = 0; rq[3] = 0;
    run_until_idle(50);
    chk("rr_count_ge4", grant_log.size() >= 4, 1);
    if (grant_log.size() >= 4) begin
      chk("rr_g0_cpu", grant_log[0], 1);
      chk("rr_g1_ext", grant_log[1], 3);
      chk("rr_g2_cpu", grant_log[2], 1);
      chk("rr_g3_ext", grant_log[3], 3);
    end
    chk("rr_x_done_seen", xd_cnt >= 2, 1);

    // ack on the last allowed BUSY cycle
    force_d = TO; use_fdata = 1; fdata = 32'h1234_5678;
    rq[1] = 1; ra[1] = 32'h3000;
    run_until_idle(60);
    chk("edge_no_err", timeout_err, 0);
    chk("edge_read_data", read_data, 32'h1234_5678);
    chk("edge_latency", rv_cyc - last_dec, TO + 1);

    // watchdog expiry, then a second one
    force_d = 0;
    rq[1] = 1; ra[1] = 32'h2000;
    run_until_idle(60);
    chk("to_latency", rv_cyc - last_dec, TO + 1);
    chk("to_err", timeout_err, 1);
    chk("to_err_adr", err_adr, 32'h2000);
    chk("to_read_data", read_data, 32'hFFFF_FFFF);
    rq[2] = 1; ra[2] = 32'h2400; rd[2] = 32'h5555_AAAA;
    run_until_idle(60);
    chk("to2_latency", wf_cyc - last_dec, TO + 1);
    chk("to2_err_adr_kept", err_adr, 32'h2000);
    chk("to2_read_data_kept", read_data, 32'hFFFF_FFFF);

    // reset in the middle of BUSY
    force_d = 0;
    rq[0] = 1; ra[0] = 32'h5000; rw[0] = 1;
    step(); step(); step();
    chk("mid_busy", m_req, 1);
    rv_cnt = 0;
    force_d = 2; fdata = 32'h7777_0000;
    pulse_reset();
    step();
    chk("mid_rst_m_req", m_req, 0);
    chk("mid_rst_err_clr", timeout_err, 0);
    run_until_idle(60);
    chk("mid_rst_one_completion", rv_cnt, 1);
    chk("mid_rst_read_data", read_data, 32'h7777_0000);

    // randomized traffic
    use_fdata = 0; force_d = -1; raise_pct = 15;
    repeat (1500) step();
    raise_pct = 0;
    run_until_idle(300);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
